// File: rtl/mux_sweep_pkg.sv
// mux_sweep_pkg
// Shared definitions for the mux-tree sweep controller: FSM state
// encoding, default variable count, maximum settle time and the width
// of the settle counter.
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam int unsigned N_VARS_DEF = 4;
  localparam int unsigned SETTLE_MAX = 7;
  localparam int unsigned settle_w   = $clog2(SETTLE_MAX + 1);

endpackage : mux_sweep_pkg

// File: rtl/mux_tree_sweep_ctrl_if.sv
// mux_tree_sweep_ctrl_if
// Bundles the host handshake and the datapath connection of the sweep
// controller.
//   master : host / datapath side (drives start, abort, exp_mask, fn_in)
//   slave  : controller side (drives var_out, busy, done, aborted,
//            tt_out, match, fail_idx)
interface mux_tree_sweep_ctrl_if
  import mux_sweep_pkg::*;
#(
  parameter int unsigned N_VARS = N_VARS_DEF
);
  localparam int unsigned TT_W = 2 ** N_VARS;

  logic              start;
  logic              abort;
  logic [TT_W-1:0]   exp_mask;
  logic [N_VARS-1:0] var_out;
  logic              fn_in;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [TT_W-1:0]   tt_out;
  logic              match;
  logic [N_VARS-1:0] fail_idx;

  modport master (
    output start, abort, exp_mask, fn_in,
    input  var_out, busy, done, aborted, tt_out, match, fail_idx
  );

  modport slave (
    input  start, abort, exp_mask, fn_in,
    output var_out, busy, done, aborted, tt_out, match, fail_idx
  );

endinterface : mux_tree_sweep_ctrl_if

// File: rtl/sweep_idx_counter.sv
// sweep_idx_counter
// Minterm index counter with a per-minterm settle counter.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : restart at minterm 0 with a fresh settle window
//   i_run      : advance the counters this cycle
//   o_idx      : current minterm index (holds when not running)
//   o_capture  : settle window elapsed; the datapath output is sampled now
//   o_last     : index is at the final minterm (counter does not wrap)
module sweep_idx_counter
  import mux_sweep_pkg::*;
#(
  parameter int unsigned N_VARS = N_VARS_DEF,
  parameter int unsigned SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_run,
  output logic [N_VARS-1:0] o_idx,
  output logic              o_capture,
  output logic              o_last
);

  logic [N_VARS-1:0]   r_idx;
  logic [settle_w-1:0] r_settle;
  logic                w_capture;
  logic                w_last;

  assign w_capture = (r_settle == settle_w'(SETTLE));
  assign w_last    = (r_idx == '1);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx    <= '0;
      r_settle <= '0;
    end else if (i_run) begin
      if (w_capture) begin
        r_settle <= '0;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign o_idx     = r_idx;
  assign o_capture = w_capture;
  assign o_last    = w_last;

endmodule : sweep_idx_counter

// File: rtl/mux_tree_sweep_ctrl.sv
// mux_tree_sweep_ctrl
// Sweeps every minterm of the mux-tree datapath, samples its output
// after SETTLE extra cycles per minterm and publishes the assembled
// truth table with a one-cycle done pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mux_tree_sweep_ctrl_if
//              (start/abort/exp_mask/fn_in in; var_out/busy/done/aborted/
//               tt_out/match/fail_idx out)
// Optional feature macro: MUX_SWEEP_CHECK_EN enables the compare against
// exp_mask (match, fail_idx); without it both outputs are tied to 0.
module mux_tree_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int unsigned N_VARS = N_VARS_DEF,
  parameter int unsigned SETTLE = 0
) (
  input logic                  clk,
  input logic                  rst,
  mux_tree_sweep_ctrl_if.slave bus
);

  localparam int unsigned TT_W = 2 ** N_VARS;

  sweep_state_e      r_state;
  sweep_state_e      w_state_nxt;
  logic              w_accept;
  logic              w_run;
  logic              w_finish;
  logic              w_abort_sweep;
  logic [N_VARS-1:0] w_idx;
  logic              w_capture;
  logic              w_last;
  logic [TT_W-1:0]   r_scratch;
  logic [TT_W-1:0]   r_tt;
  logic [TT_W-1:0]   w_final;
  logic              r_aborted;

  sweep_idx_counter #(
    .N_VARS (N_VARS),
    .SETTLE (SETTLE)
  ) u_idx_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_run     (w_run),
    .o_idx     (w_idx),
    .o_capture (w_capture),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked before capture so it wins on the last capture cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_run         = 1'b0;
    w_finish      = 1'b0;
    w_abort_sweep = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = SWEEP;
          w_accept    = 1'b1;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          w_state_nxt   = IDLE;
          w_abort_sweep = 1'b1;
        end else begin
          w_run = 1'b1;
          if (w_capture && w_last) begin
            w_state_nxt = DONE;
            w_finish    = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // tt_out must be valid in the DONE cycle itself, so it is loaded on the
  // final capture edge with the last sample merged in directly.
  always_comb begin
    w_final        = r_scratch;
    w_final[w_idx] = bus.fn_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= '0;
      r_tt      <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort_sweep;
      if (w_accept) begin
        r_scratch <= '0;
      end else if (w_run && w_capture) begin
        r_scratch[w_idx] <= bus.fn_in;
      end
      if (w_finish) begin
        r_tt <= w_final;
      end
    end
  end

  assign bus.var_out = w_idx;
  assign bus.busy    = (r_state == SWEEP);
  assign bus.done    = (r_state == DONE);
  assign bus.aborted = r_aborted;
  assign bus.tt_out  = r_tt;

`ifdef MUX_SWEEP_CHECK_EN
  logic [TT_W-1:0]   r_exp;
  logic [TT_W-1:0]   w_diff;
  logic              r_match;
  logic [N_VARS-1:0] r_fail_idx;
  logic [N_VARS-1:0] w_fail_idx;

  assign w_diff = w_final ^ r_exp;

  // Scan from the top down so the lowest differing index is kept.
  always_comb begin
    w_fail_idx = '0;
    for (int unsigned i = TT_W; i > 0; i--) begin
      if (w_diff[i-1]) begin
        w_fail_idx = N_VARS'(i - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp      <= '0;
      r_match    <= 1'b0;
      r_fail_idx <= '0;
    end else begin
      if (w_accept) begin
        r_exp <= bus.exp_mask;
      end
      if (w_finish) begin
        r_match    <= (w_diff == '0);
        r_fail_idx <= w_fail_idx;
      end
    end
  end

  assign bus.match    = r_match;
  assign bus.fail_idx = r_fail_idx;
`else
  logic w_unused_exp;
  assign w_unused_exp = ^bus.exp_mask;
  assign bus.match    = 1'b0;
  assign bus.fail_idx = '0;
`endif

endmodule : mux_tree_sweep_ctrl

// File: tb/tb_mux_tree_sweep_ctrl.sv
// tb_mux_tree_sweep_ctrl
// Two controllers (SETTLE=0 and SETTLE=2) share one stimulus and one
// datapath truth table; each is compared every cycle with a cycle-count
// reference model, plus directed scenario checks.
module tb_mux_tree_sweep_ctrl;
  import mux_sweep_pkg::*;

  localparam int unsigned NV = 4;
  localparam int TT = 16;
`ifdef MUX_SWEEP_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_mask = '0;
  logic [15:0] dp_tt = 16'h3C5A;

  mux_tree_sweep_ctrl_if #(.N_VARS(NV)) bus0 ();
  mux_tree_sweep_ctrl_if #(.N_VARS(NV)) bus2 ();

  assign bus0.start    = start;
  assign bus0.abort    = abort;
  assign bus0.exp_mask = exp_mask;
  assign bus0.fn_in    = dp_tt[bus0.var_out];
  assign bus2.start    = start;
  assign bus2.abort    = abort;
  assign bus2.exp_mask = exp_mask;
  assign bus2.fn_in    = dp_tt[bus2.var_out];

  mux_tree_sweep_ctrl #(.N_VARS(NV), .SETTLE(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mux_tree_sweep_ctrl #(.N_VARS(NV), .SETTLE(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model. m_t: 0 = idle, 1..B = cycle number within the sweep,
  // B+1 = done cycle, where B = 16*(S+1).
  int          S_OF [2] = '{0, 2};
  int          m_t [2];
  logic [3:0]  m_var [2];
  logic [15:0] m_scr [2];
  logic [15:0] m_tt [2];
  logic [15:0] m_exp [2];
  logic        m_match [2];
  logic [3:0]  m_fail [2];
  logic        m_abrt [2];
  bit          m_live = 1'b0;

  function automatic void ref_cmp(input logic [15:0] got, input logic [15:0] want,
                                  output logic m, output logic [3:0] f);
    m = 1'b0;
    f = '0;
    if (CK) begin
      m = (got == want);
      for (int i = 15; i >= 0; i--) begin
        if (got[i] != want[i]) f = 4'(i);
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int s, b, t;
      logic [3:0] v, fi;
      logic [15:0] sc, tt, ex;
      logic mt, ab;
      s = S_OF[k]; b = TT * (s + 1); t = m_t[k];
      v = m_var[k]; sc = m_scr[k]; tt = m_tt[k]; ex = m_exp[k];
      mt = m_match[k]; fi = m_fail[k]; ab = 1'b0;
      if (rst) begin
        t = 0; v = '0; sc = '0; tt = '0; mt = 1'b0; fi = '0;
      end else if (t >= 1 && t <= b) begin
        v = 4'((t - 1) / (s + 1));
        if (abort) begin
          t = 0; ab = 1'b1;
        end else begin
          if (t % (s + 1) == 0) sc[v] = dp_tt[v];
          if (t == b) begin
            t = b + 1; tt = sc; ref_cmp(sc, ex, mt, fi);
          end else begin
            t = t + 1;
          end
        end
      end else if (t == b + 1) begin
        t = 0;
      end else if (start && !abort) begin
        t = 1; sc = '0; ex = exp_mask;
      end
      m_t[k] <= t; m_var[k] <= v; m_scr[k] <= sc; m_tt[k] <= tt;
      m_exp[k] <= ex; m_match[k] <= mt; m_fail[k] <= fi; m_abrt[k] <= ab;
    end
    if (rst) m_live <= 1'b1;
  end

  task automatic chk_inst(input int k, input logic b, input logic d, input logic a,
                          input logic [3:0] v, input logic [15:0] tt,
                          input logic m, input logic [3:0] f);
    int s = S_OF[k];
    int bl = TT * (s + 1);
    int t = m_t[k];
    logic busy_e = (t >= 1 && t <= bl);
    logic [3:0] v_e = busy_e ? 4'((t - 1) / (s + 1)) : m_var[k];
    chk($sformatf("s%0d_busy", s), 32'(b), 32'(busy_e));
    chk($sformatf("s%0d_done", s), 32'(d), 32'(t == bl + 1));
    chk($sformatf("s%0d_aborted", s), 32'(a), 32'(m_abrt[k]));
    chk($sformatf("s%0d_var_out", s), 32'(v), 32'(v_e));
    chk($sformatf("s%0d_tt_out", s), 32'(tt), 32'(m_tt[k]));
    chk($sformatf("s%0d_match", s), 32'(m), 32'(m_match[k]));
    chk($sformatf("s%0d_fail_idx", s), 32'(f), 32'(m_fail[k]));
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk_inst(0, bus0.busy, bus0.done, bus0.aborted, bus0.var_out, bus0.tt_out,
               bus0.match, bus0.fail_idx);
      chk_inst(1, bus2.busy, bus2.done, bus2.aborted, bus2.var_out, bus2.tt_out,
               bus2.match, bus2.fail_idx);
    end
  end

  // Called at a negedge; start is sampled at the next edge (edge 0).
  task automatic run_sweep(input logic [15:0] dp, input logic [15:0] ex, input bit poke,
                           input logic [15:0] e_tt, input logic e_m, input logic [3:0] e_f);
    int c0 = 0, c2 = 0, nb = 0;
    logic [15:0] t0 = '0, t2 = '0;
    logic m0 = 1'b0, m2 = 1'b0;
    logic [3:0] f0 = '0, f2 = '0;
    dp_tt = dp;
    exp_mask = ex;
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start = poke && (c == 5 || c == 12);
      if (bus0.done && c0 == 0) begin
        c0 = c; t0 = bus0.tt_out; m0 = bus0.match; f0 = bus0.fail_idx;
      end
      if (bus2.done && c2 == 0) begin
        c2 = c; t2 = bus2.tt_out; m2 = bus2.match; f2 = bus2.fail_idx;
      end
      if (bus2.busy) nb++;
    end
    start = 1'b0;
    chk("dir_done_cycle_s0", 32'(c0), 32'd17);
    chk("dir_done_cycle_s2", 32'(c2), 32'd49);
    chk("dir_busy_len_s2", 32'(nb), 32'd48);
    chk("dir_tt_s0", 32'(t0), 32'(e_tt));
    chk("dir_tt_s2", 32'(t2), 32'(e_tt));
    chk("dir_match_s0", 32'(m0), 32'(e_m));
    chk("dir_match_s2", 32'(m2), 32'(e_m));
    chk("dir_fail_s0", 32'(f0), 32'(e_f));
    chk("dir_fail_s2", 32'(f2), 32'(e_f));
  endtask

  initial begin
    int ndone;
    logic [15:0] rnd;
    repeat (3) @(negedge clk);
    chk("rst_tt_s0", 32'(bus0.tt_out), 32'd0);
    chk("rst_busy_s2", 32'(bus2.busy), 32'd0);
    chk("rst_var_s2", 32'(bus2.var_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Golden datapath, then stuck-at-0 on minterm 6.
    run_sweep(16'h3C5A, 16'h3C5A, 1'b0, 16'h3C5A, CK, 4'd0);
    run_sweep(16'h3C1A, 16'h3C5A, 1'b0, 16'h3C1A, 1'b0, CK ? 4'd6 : 4'd0);

    // Prior result 3C5A, then an abort during cycle 8.
    run_sweep(16'h3C5A, 16'h3C5A, 1'b0, 16'h3C5A, CK, 4'd0);
    ndone = 0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus0.done || bus2.done) ndone++;
      if (c == 8) abort = 1'b1;
      if (c == 9) begin
        abort = 1'b0;
        chk("abort_pulse_s0", 32'(bus0.aborted), 32'd1);
        chk("abort_pulse_s2", 32'(bus2.aborted), 32'd1);
        chk("abort_tt_keep_s0", 32'(bus0.tt_out), 32'h3C5A);
        chk("abort_busy_s2", 32'(bus2.busy), 32'd0);
      end
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_sweep(16'h3C5A, 16'h3C5A, 1'b1, 16'h3C5A, CK, 4'd0);

    // start together with abort in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_s0", 32'(bus0.busy), 32'd0);
    chk("start_abort_idle_s2", 32'(bus2.busy), 32'd0);
    @(negedge clk);

    // Reset asserted in cycle 10 of a sweep.
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        rst = 1'b0;
        chk("midrst_busy_s2", 32'(bus2.busy), 32'd0);
        chk("midrst_var_s2", 32'(bus2.var_out), 32'd0);
        chk("midrst_tt_s0", 32'(bus0.tt_out), 32'd0);
        chk("midrst_pulses", 32'({bus0.done, bus0.aborted, bus2.done, bus2.aborted}), 32'd0);
      end
    end
    rnd = 16'($urandom);
    run_sweep(rnd, rnd, 1'b0, rnd, CK, 4'd0);

    // Randomized traffic; the per-cycle model checks everything.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 5) == 0) dp_tt = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        exp_mask = ($urandom_range(0, 1) == 0) ? dp_tt : (dp_tt ^ 16'(1 << $urandom_range(0, 15)));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    repeat (60) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_tree_sweep_ctrl
